reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- Architectural register file that sits at the receiving end of the write-back interface (wb_en / wb_dest / wb_val).
- Holds 16 x 32-bit registers. Provides two combinational read ports to the ID stage.
- Contains a per-register pending-write scoreboard. ID increments it on issue; write-back decrements it. The scoreboard drives the RAW-hazard stall.
- Optional write-through bypass lets an ID read be satisfied in the same cycle as the final write-back.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 4, register index width (2**ADDR_W registers).
- CNT_W, 2, pending-counter width. Maximum in-flight writes per register = 2**CNT_W-1 = 3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wb_en_i  in  1  write-back valid.
- wb_dest_i  in  ADDR_W  write-back destination register.
- wb_val_i  in  DATA_W  write-back data.
- src1_i  in  ADDR_W  read port 1 index (Rn).
- src2_i  in  ADDR_W  read port 2 index (Rm or Rd for stores).
- src1_use_i  in  1  port 1 operand is consumed by the ID instruction.
- src2_use_i  in  1  port 2 operand is consumed.
- issue_en_i  in  1  ID issues an instruction that will write a register.
- issue_dest_i  in  ADDR_W  destination of the issued instruction.
- reg1_o  out  DATA_W  read data, port 1.
- reg2_o  out  DATA_W  read data, port 2.
- hazard_o  out  1  RAW hazard; ID must stall.
- pending_o  out  2**ADDR_W  bit i = register i has at least one write in flight.
- err_o  out  1  sticky scoreboard over/underflow flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0, all counters = 0, err_o = 0.
  - Consequently reg1_o = reg2_o = 0, hazard_o = 0, pending_o = 0.
- Write: on posedge clk, if wb_en_i, regs[wb_dest_i] <= wb_val_i. No write when wb_en_i = 0.
- Read: reg1_o and reg2_o are combinational from the array (zero latency). Bypass is defined under Optional Feature.
- Counter update per register r, on each posedge clk:
  - inc = issue_en_i && issue_dest_i == r
  - dec = wb_en_i && wb_dest_i == r
  - inc && dec: count unchanged.
  - inc only: count + 1. If count = 3, hold at 3 and set err_o.
  - dec only: count - 1. If count = 0, hold at 0 and set err_o (write-back with no matching issue).
  - neither: hold.
- err_o stays set until reset.
- pending_o[r] = (count[r] != 0). Combinational from the registered counts.
- Issue is not gated internally. The controller must not assert issue_en_i while hazard_o = 1. If it does, the counter still increments.
- Hazard: hazard_o = h1 | h2, where hN = srcN_use_i && count[srcN] != 0 && !bypass_okN.
  - bypass_okN = wb_en_i && wb_dest_i == srcN && count[srcN] == 1 (bypass build only; otherwise 0).
- src1_i == src2_i: both ports behave identically and independently.
- A write-back that does not match a read source never affects that port's output.
- Reset asserted mid-operation clears all in-flight tracking. The pipeline is reset simultaneously.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined:
  - reg_oN = wb_val_i when wb_en_i && wb_dest_i == srcN; otherwise regs[srcN].
  - bypass_okN is active as defined above, so the final outstanding write-back releases the stall in the same cycle.
- Undefined:
  - reg_oN = regs[srcN] only; bypass_okN = 0.
  - The stall persists until the cycle after the final write-back. This adds one cycle of RAW penalty.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_ADDR_W = 4 and REG_DATA_W = 32
  - the reg_idx_t / word_t typedefs
  - the PC index constant REG_PC = 4'd15
- One natural sub-module, sb_counter: a single saturating inc/dec counter with an error pulse. It is instantiated 2**ADDR_W times via generate.
- Read muxes and the register array stay in reg_file_wb.

Test Plan:
1. Reset check: assert rst=0 mid-run after writes → all reads 0, pending_o = 16'h0000, err_o = 0, hazard_o = 0, independent of clk.
2. Basic write/read: wb_en_i=1, wb_dest_i=3, wb_val_i=32'hDEAD_BEEF for one cycle; next cycle src1_i=3 → reg1_o = 32'hDEADBEEF, with no issue activity.
3. RAW stall:
   - Issue dest=5 in cycle 0; in cycle 1 read src2_i=5 with src2_use_i=1 → hazard_o=1, pending_o[5]=1.
   - Write-back dest=5, value 32'h1234 in cycle 3:
     - bypass build: hazard_o=0 and reg2_o=32'h1234 in cycle 3.
     - non-bypass build: hazard_o=0 in cycle 4.
4. Multiple in-flight: issue dest=7 in three consecutive cycles → count 3. Two write-backs → hazard still 1. Third write-back → hazard clears (same cycle in the bypass build, next cycle otherwise).
5. Simultaneous issue + write-back: count[2]=1, then issue dest=2 and write-back dest=2 in the same cycle → pending_o[2] stays 1 and reg updated.
6. Error: a fourth issue to dest=9 with count=3 → err_o=1 and count stays 3. Separately, a write-back to dest=4 with count 0 → err_o=1 and the register is still written.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-file geometry, index/word types and the PC index.
package pipe_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int SB_CNT_W   = 2;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [REG_DATA_W-1:0] word_t;

  localparam reg_idx_t REG_PC = 4'd15;

endpackage

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one register; err_o pulses on an over/underflow attempt.
module sb_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_s;

  // Next count: simultaneous inc/dec cancel, saturate at both ends and flag the attempt.
  always_comb begin
    cnt_d = cnt_q;
    err_s = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CNT_MAX) begin
          err_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (cnt_q == CNT_MIN) begin
          err_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= CNT_MIN;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_s;

endmodule

// File: rtl/reg_file_wb.sv
// 16x32 architectural register file with per-register pending-write scoreboard and RAW stall.
// Build option REG_FILE_BYPASS_EN: forward the write-back value to reads and release the stall same cycle.
module reg_file_wb
  import pipe_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = SB_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_en_i,
  input  logic [ADDR_W-1:0]    wb_dest_i,
  input  logic [DATA_W-1:0]    wb_val_i,
  input  logic [ADDR_W-1:0]    src1_i,
  input  logic [ADDR_W-1:0]    src2_i,
  input  logic                 src1_use_i,
  input  logic                 src2_use_i,
  input  logic                 issue_en_i,
  input  logic [ADDR_W-1:0]    issue_dest_i,
  output logic [DATA_W-1:0]    reg1_o,
  output logic [DATA_W-1:0]    reg2_o,
  output logic                 hazard_o,
  output logic [2**ADDR_W-1:0] pending_o,
  output logic                 err_o
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};

  logic [DATA_W-1:0]           regs_q [NREG];
  logic [NREG-1:0][CNT_W-1:0]  cnt_s;
  logic [NREG-1:0]             inc_s;
  logic [NREG-1:0]             dec_s;
  logic [NREG-1:0]             cnt_err_s;
  logic                        err_q;
  logic                        err_d;
  logic                        bypass_ok1_s;
  logic                        bypass_ok2_s;
  logic                        h1_s;
  logic                        h2_s;

  // Register array write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en_i) begin
      regs_q[wb_dest_i] <= wb_val_i;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_sb
    assign inc_s[g] = issue_en_i && (issue_dest_i == ADDR_W'(g));
    assign dec_s[g] = wb_en_i && (wb_dest_i == ADDR_W'(g));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (inc_s[g]),
      .dec_i (dec_s[g]),
      .cnt_o (cnt_s[g]),
      .err_o (cnt_err_s[g])
    );

    assign pending_o[g] = (cnt_s[g] != CNT_MIN);
  end

  // Sticky error: any counter over/underflow attempt latches until reset.
  always_comb begin
    if (|cnt_err_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Read muxes; the bypass build forwards a matching write-back and lets the last one release the stall.
  always_comb begin
    reg1_o       = regs_q[src1_i];
    reg2_o       = regs_q[src2_i];
    bypass_ok1_s = 1'b0;
    bypass_ok2_s = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (wb_en_i && (wb_dest_i == src1_i)) begin
      reg1_o = wb_val_i;
    end else begin
      reg1_o = regs_q[src1_i];
    end
    if (wb_en_i && (wb_dest_i == src2_i)) begin
      reg2_o = wb_val_i;
    end else begin
      reg2_o = regs_q[src2_i];
    end
    bypass_ok1_s = wb_en_i && (wb_dest_i == src1_i) && (cnt_s[src1_i] == CNT_ONE);
    bypass_ok2_s = wb_en_i && (wb_dest_i == src2_i) && (cnt_s[src2_i] == CNT_ONE);
`endif
  end

  // RAW hazard per read port.
  always_comb begin
    h1_s = src1_use_i && (cnt_s[src1_i] != CNT_MIN) && !bypass_ok1_s;
    h2_s = src2_use_i && (cnt_s[src2_i] != CNT_MIN) && !bypass_ok2_s;
  end

  assign hazard_o = h1_s | h2_s;
  assign err_o    = err_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus randomized traffic against a reference model.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_val;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        src1_use;
  logic        src2_use;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        hazard;
  logic [15:0] pending;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [16];
  int          m_cnt  [16];
  bit          m_err;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_wb dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_i      (wb_en),
    .wb_dest_i    (wb_dest),
    .wb_val_i     (wb_val),
    .src1_i       (src1),
    .src2_i       (src2),
    .src1_use_i   (src1_use),
    .src2_use_i   (src2_use),
    .issue_en_i   (issue_en),
    .issue_dest_i (issue_dest),
    .reg1_o       (reg1),
    .reg2_o       (reg2),
    .hazard_o     (hazard),
    .pending_o    (pending),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] s);
    if (BYP && wb_en && wb_dest == s) return wb_val;
    return m_regs[s];
  endfunction

  function automatic bit exp_port_hazard(input bit use_s, input logic [3:0] s);
    bit ok;
    ok = BYP && wb_en && wb_dest == s && m_cnt[s] == 1;
    return use_s && m_cnt[s] != 0 && !ok;
  endfunction

  function automatic logic [15:0] exp_pending();
    logic [15:0] p;
    for (int r = 0; r < 16; r++) p[r] = (m_cnt[r] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = 32'h0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_update();
    for (int r = 0; r < 16; r++) begin
      bit inc, dec;
      inc = issue_en && issue_dest == r;
      dec = wb_en && wb_dest == r;
      if (inc && !dec) begin
        if (m_cnt[r] == 3) m_err = 1'b1;
        else m_cnt[r]++;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1'b1;
        else m_cnt[r]--;
      end
    end
    if (wb_en) m_regs[wb_dest] = wb_val;
  endtask

  task automatic idle();
    wb_en = 1'b0; wb_dest = 4'd0; wb_val = 32'h0;
    issue_en = 1'b0; issue_dest = 4'd0;
    src1 = 4'd0; src2 = 4'd0; src1_use = 1'b0; src2_use = 1'b0;
  endtask

  // Compare all outputs with the model, clock once, advance the model.
  task automatic tick();
    check_eq("reg1", reg1, exp_read(src1));
    check_eq("reg2", reg2, exp_read(src2));
    check_eq("hazard", {31'h0, hazard}, {31'h0, exp_port_hazard(src1_use, src1) | exp_port_hazard(src2_use, src2)});
    check_eq("pending", {16'h0, pending}, {16'h0, exp_pending()});
    check_eq("err", {31'h0, err}, {31'h0, m_err});
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pending", {16'h0, pending}, 32'h0);
    check_eq("rst_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic write then read.
    wb_en = 1'b1; wb_dest = 4'd3; wb_val = 32'hDEAD_BEEF; #1; tick();
    idle(); src1 = 4'd3; #1;
    check_eq("basic_rd", reg1, 32'hDEADBEEF);
    tick();

    // RAW stall on register 5.
    idle(); issue_en = 1'b1; issue_dest = 4'd5; #1; tick();
    idle(); src2 = 4'd5; src2_use = 1'b1; #1;
    check_eq("raw_haz_c1", {31'h0, hazard}, 32'h1);
    check_eq("raw_pend5", {31'h0, pending[5]}, 32'h1);
    tick();
    tick();
    wb_en = 1'b1; wb_dest = 4'd5; wb_val = 32'h1234; #1;
    check_eq("raw_haz_c3", {31'h0, hazard}, BYP ? 32'h0 : 32'h1);
    if (BYP) check_eq("raw_byp_val", reg2, 32'h1234);
    tick();
    wb_en = 1'b0; #1;
    check_eq("raw_haz_c4", {31'h0, hazard}, 32'h0);
    check_eq("raw_val_c4", reg2, 32'h1234);
    tick();

    // Three writes in flight to register 7.
    idle(); issue_en = 1'b1; issue_dest = 4'd7;
    repeat (3) begin #1; tick(); end
    idle(); src1 = 4'd7; src1_use = 1'b1; wb_en = 1'b1; wb_dest = 4'd7;
    for (int k = 0; k < 2; k++) begin
      wb_val = 32'h7000 + k; #1;
      check_eq("multi_haz", {31'h0, hazard}, 32'h1);
      tick();
    end
    wb_val = 32'h7777; #1;
    check_eq("multi_haz_last", {31'h0, hazard}, BYP ? 32'h0 : 32'h1);
    tick();
    wb_en = 1'b0; #1;
    check_eq("multi_clear", {31'h0, hazard}, 32'h0);
    tick();

    // Simultaneous issue and write-back to register 2.
    idle(); issue_en = 1'b1; issue_dest = 4'd2; #1; tick();
    wb_en = 1'b1; wb_dest = 4'd2; wb_val = 32'hAA55_AA55; #1; tick();
    idle(); src2 = 4'd2; #1;
    check_eq("simul_pend2", {31'h0, pending[2]}, 32'h1);
    check_eq("simul_val", reg2, 32'hAA55AA55);
    tick();
    wb_en = 1'b1; wb_dest = 4'd2; wb_val = 32'h2; #1; tick();

    // Asynchronous reset mid-cycle with state present.
    idle(); issue_en = 1'b1; issue_dest = 4'd11; #1; tick();
    idle(); wb_en = 1'b1; wb_dest = 4'd6; wb_val = 32'h6666; #1; tick();
    idle(); src1 = 4'd11; src1_use = 1'b1; src2 = 4'd6; #1;
    check_eq("pre_rst_haz", {31'h0, hazard}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_reg2", reg2, 32'h0);
    check_eq("arst_haz", {31'h0, hazard}, 32'h0);
    check_eq("arst_pend", {16'h0, pending}, 32'h0);
    check_eq("arst_err", {31'h0, err}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Overflow on register 9.
    idle(); issue_en = 1'b1; issue_dest = 4'd9;
    repeat (4) begin #1; tick(); end
    idle(); #1;
    check_eq("ovf_err", {31'h0, err}, 32'h1);
    check_eq("ovf_pend9", {31'h0, pending[9]}, 32'h1);
    wb_en = 1'b1; wb_dest = 4'd9;
    repeat (3) begin #1; tick(); end
    idle(); #1;
    check_eq("ovf_drained", {31'h0, pending[9]}, 32'h0);
    tick();

    // Underflow on register 4: error set but data still written.
    do_reset();
    wb_en = 1'b1; wb_dest = 4'd4; wb_val = 32'h4444_0004; #1; tick();
    idle(); src1 = 4'd4; #1;
    check_eq("udf_err", {31'h0, err}, 32'h1);
    check_eq("udf_val", reg1, 32'h44440004);
    tick();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int pend_list [$];
      idle();
      for (int r = 0; r < 16; r++) if (m_cnt[r] != 0) pend_list.push_back(r);
      issue_en   = ($urandom_range(0, 9) < 4);
      issue_dest = 4'($urandom_range(0, 15));
      wb_en      = ($urandom_range(0, 9) < 4);
      if (pend_list.size() != 0 && $urandom_range(0, 9) < 8)
        wb_dest = 4'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
      else
        wb_dest = 4'($urandom_range(0, 15));
      wb_val   = $urandom;
      src1     = ($urandom_range(0, 1) == 0) ? wb_dest : 4'($urandom_range(0, 15));
      src2     = ($urandom_range(0, 3) == 0) ? src1 : 4'($urandom_range(0, 15));
      src1_use = $urandom_range(0, 1);
      src2_use = $urandom_range(0, 1);
      #1;
      tick();
      if (c == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
